// File: rtl/bcd_result_deframer.sv
// bcd_result_deframer: serial result frame receiver with one-entry valid/ready output buffer
module bcd_result_deframer #(
  parameter int COUNT_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               din,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic [3:0]         F4,
  output logic [3:0]         F3,
  output logic [3:0]         F2,
  output logic [3:0]         F1,
  output logic [3:0]         F0,
  output logic               digit_err,
  output logic               overrun,
  output logic [COUNT_W-1:0] frame_count
);
  typedef enum logic {HUNT, CAPTURE} state_t;
  localparam logic [7:0] HDR = 8'b1001_0110;
  state_t state_q, state_d;
  logic [6:0] win_q, win_d;
  logic [18:0] pay_q, pay_d;
  logic [4:0] cnt_q, cnt_d;
  logic valid_q, valid_d;
  logic [19:0] dig_q, dig_d;
  logic err_q, err_d;
  logic ovr_q, ovr_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [7:0] win_sh;
  logic [19:0] pay_sh;
  logic done, accept, bad;
  assign win_sh = {win_q, din};
  assign pay_sh = {pay_q, din};
  assign done = (state_q == CAPTURE) && (cnt_q == 5'd19);
  assign accept = !valid_q || dout_ready;
  assign bad = (pay_sh[19:16] > 4'd1) || (pay_sh[15:12] > 4'd9) || (pay_sh[11:8] > 4'd9)
            || (pay_sh[7:4] > 4'd9) || (pay_sh[3:0] > 4'd9);
  // Header hunt, payload capture and holding-register handshake
  always_comb begin
    state_d = state_q;
    win_d = win_q;
    pay_d = pay_q;
    cnt_d = cnt_q;
    valid_d = valid_q;
    dig_d = dig_q;
    err_d = err_q;
    ovr_d = ovr_q;
    count_d = count_q;
    if (state_q == HUNT) begin
      win_d = win_sh[6:0];
      state_d = (win_sh == HDR) ? CAPTURE : HUNT;
      cnt_d = 5'd0;
    end else begin
      pay_d = pay_sh[18:0];
      cnt_d = cnt_q + 5'd1;
      state_d = done ? HUNT : CAPTURE;
      win_d = done ? 7'd0 : win_q;
    end
    if (done && accept) begin
      valid_d = 1'b1;
      dig_d = pay_sh;
      err_d = bad;
      count_d = count_q + COUNT_W'(1);
    end else if (done) begin
      ovr_d = 1'b1;
    end else if (dout_ready) begin
      valid_d = 1'b0;
    end
  end
  // State registers with asynchronous reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= HUNT;
      win_q <= '0;
      pay_q <= '0;
      cnt_q <= '0;
      valid_q <= 1'b0;
      dig_q <= '0;
      err_q <= 1'b0;
      ovr_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      win_q <= win_d;
      pay_q <= pay_d;
      cnt_q <= cnt_d;
      valid_q <= valid_d;
      dig_q <= dig_d;
      err_q <= err_d;
      ovr_q <= ovr_d;
      count_q <= count_d;
    end
  end
  assign dout_valid = valid_q;
  assign {F4, F3, F2, F1, F0} = dig_q;
  assign digit_err = err_q;
  assign overrun = ovr_q;
  assign frame_count = count_q;
endmodule

// File: doc/bcd_result_deframer.md
# bcd_result_deframer

Serial-to-parallel receiver on the BCD ALU's serial `result` output. It hunts for the 8-bit result header and captures the 20-bit payload that follows. It presents the five result digits in parallel, holding them in a one-entry buffer behind a valid/ready handshake. It also flags malformed digits, reports dropped frames, and counts delivered frames.

## Interface
Parameters:
- `COUNT_W`, default 8: width of the delivered-frame counter.

Ports:
- `clock`: input, 1 bit. Single clock; all sampling on the rising edge.
- `reset`: input, 1 bit. Asynchronous, active-high.
- `din`: input, 1 bit. Serial result stream, one bit per clock.
- `dout_valid`: output, 1 bit. Holding register contains an undelivered frame.
- `dout_ready`: input, 1 bit. Consumer accepts the frame when `dout_valid & dout_ready` at a rising edge.
- `F4`, `F3`, `F2`, `F1`, `F0`: output, 4 bits each. Result digits; `F4` is the carry/MSD and `F0` the LSD.
- `digit_err`: output, 1 bit. Qualified by `dout_valid`. Set when any of F3..F0 > 9 or F4 > 1.
- `overrun`: output, 1 bit. Sticky; a completed frame was dropped.
- `frame_count`: output, `COUNT_W` bits. Number of frames loaded into the holding register; wraps modulo 2^COUNT_W.

## Operation
Frame format, in time order:
- Header: 8 bits, 1,0,0,1,0,1,1,0.
- Payload: 20 bits. Digits are sent F4, F3, F2, F1, F0, each MSB first.
- Idle line is 0.

State machine:
- HUNT:
  - An 8-bit window holds the last 8 sampled bits.
  - When the window, oldest to newest, equals the header at a sampling edge, go to CAPTURE and clear the bit counter.
- CAPTURE:
  - Shift `din` into a 20-bit payload register each edge and increment the bit counter.
  - Header-like patterns inside the payload are ignored; there is no re-sync mid-frame.
  - On the edge that samples payload bit 20, perform the completion action, clear the window to 0, and return to HUNT.
- Completion action:
  - Holding register empty, or being drained at this same edge: load the digits and `digit_err`, keep or raise `dout_valid`, and increment `frame_count`.
  - Holding register full and not drained: discard the new frame, set `overrun`, and leave the held data, `digit_err` and `frame_count` unchanged.
- Handshake:
  - A drain with no completion at that edge clears `dout_valid`.
  - F4..F0 and `digit_err` hold their last values after a drain.
  - `dout_valid` never drops while `dout_ready` is low.

Reset (asserted at any time, including mid-frame):
- State returns to HUNT; window, payload and bit counter clear.
- `dout_valid`=0, F4..F0=0, `digit_err`=0, `overrun`=0, `frame_count`=0.
- The all-zero window cannot match the header, so no false frame is detected after reset.

## Timing
- Header bit 8 sampled at edge k, payload bits at edges k+1..k+20.
- `dout_valid` and the digits update after edge k+20, which is one cycle after the last payload bit is on `din`.
- Back-to-back frames are supported: the next header's first bit may be sampled at edge k+21, giving a minimum frame period of 28 cycles.
- `overrun` rises after edge k+20 of the dropped frame.
- `frame_count` updates on the same edge as the load.
- All outputs are registered; there are no combinational paths from `din` or `dout_ready` to outputs.

## Test plan
- Frame recovery: after reset, drive 4 idle zeros, then the header, then payload 0000 0001 0010 0011 0100, with `dout_ready`=1. Required: one edge after the last bit, `dout_valid`=1, F4..F0=0,1,2,3,4, `digit_err`=0, `frame_count`=1; `dout_valid`=0 on the next edge.
- False sync: drive 1,0,0,1,0,1,1,1, then zeros. Required: no capture, `dout_valid` stays 0. Then drive a valid frame whose payload itself contains 1,0,0,1,0,1,1,0 (digits 1,0,9,6,0). Required: digits 1,0,9,6,0 are delivered intact.
- Digit error: payload digits 0,10,0,0,0, and separately 2,0,0,0,0. Required: `digit_err`=1 for both frames, with digits output raw (0,A,0,0,0 and 2,0,0,0,0).
- Overrun: hold `dout_ready`=0 and send two back-to-back frames (digits 0,1,1,1,1 then 0,2,2,2,2). Required: held digits stay 0,1,1,1,1, `overrun`=1, `frame_count`=1. After `dout_ready` pulses, `dout_valid`=0 and `overrun` stays 1.
- Simultaneous drain and completion: `dout_ready` is high on exactly the completion edge of frame 2 while frame 1 is held. Required: frame 2 digits are loaded, `dout_valid` stays 1, `overrun`=0, `frame_count`=2.
- Reset mid-frame: assert `reset` asynchronously after 10 payload bits. Required: all outputs are 0 immediately. After release, a fresh frame (1,9,9,9,9) is captured correctly with `frame_count`=1.
